// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM states and RV32I decode constants.
// The fetch unit and control unit both import this package.
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0: the CU treats this as a no-op while no live instruction is in I.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential PC+4 (wrapping) or the ALU branch target,
// forced to a word boundary because misaligned targets are not trapped.
module pc_next
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            PCSel,
  input  logic [XLEN-1:0] ALUout,
  output logic [XLEN-1:0] next_pc
);

  always_comb begin
    next_pc = pc + 32'd4;
    if (PCSel) begin
      next_pc = ALUout & ~32'h0000_0003;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: requests a word, latches it into I for the CU,
// holds it for EXEC_CYCLES cycles (EXEC_CYCLES must be 1..15), then advances the PC.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              EXEC_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCSel,
  input  logic [XLEN-1:0] ALUout,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] I,
  output logic [XLEN-1:0] PC,
  output logic            inst_valid
);

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic [3:0]      cnt;

  pc_next u_pc_next (
    .pc      (pc),
    .PCSel   (PCSel),
    .ALUout  (ALUout),
    .next_pc (next_pc)
  );

  // pc only changes when leaving EXEC, so the address is stable for all of FETCH.
  assign imem_addr = pc;

  // imem_req is registered, so the very first FETCH after reset spends one extra
  // cycle raising it; every later FETCH gets it on the edge that leaves EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      PC         <= RESET_PC;
      cnt        <= 4'd0;
      imem_req   <= 1'b0;
      I          <= NOP_INSTR;
      inst_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_req && imem_ready) begin
            imem_req <= 1'b0;
            state    <= WAIT;
          end else begin
            imem_req <= 1'b1;
          end
        end

        WAIT: begin
          if (imem_rvalid) begin
            I          <= imem_rdata;
            PC         <= pc;
            inst_valid <= 1'b1;
            cnt        <= CNT_LOAD;
            state      <= EXEC;
          end
        end

        EXEC: begin
          if (!stall) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              pc         <= next_pc;
              inst_valid <= 1'b0;
              imem_req   <= 1'b1;
              state      <= FETCH;
            end
          end
        end

        default: begin
          imem_req <= 1'b0;
          state    <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, branches, back-pressure,
// stall with PC wrap, and reset in the middle of a memory read.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        rst_n_w;
  logic        PCSel;
  logic [31:0] ALUout;
  logic        stall;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] I;
  logic [31:0] PC;
  logic        inst_valid;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_I;
  logic [31:0] w_PC;
  logic        w_inst_valid;

  integer tests;
  integer fails;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .PCSel(PCSel), .ALUout(ALUout), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .I(I), .PC(PC), .inst_valid(inst_valid)
  );

  // Second instance starts just below the top of the address space to exercise wrap.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .EXEC_CYCLES(3)) dut_w (
    .clk(clk), .rst_n(rst_n_w), .PCSel(PCSel), .ALUout(ALUout), .stall(stall),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .I(w_I), .PC(w_PC), .inst_valid(w_inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n_w = 1'b0; PCSel = 1'b0; ALUout = 32'h0; stall = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #1;
    repeat (3) step();
    tests++; if (I !== 32'h0000_0013) begin fails++; $display("[TB] FAIL reset_I: got %h expected 00000013", I); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", inst_valid); end
    tests++; if (PC !== 32'h0) begin fails++; $display("[TB] FAIL reset_PC: got %h expected 00000000", PC); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("[TB] FAIL reset_addr: got %h expected 00000000", imem_addr); end
    rst_n = 1'b1;
    imem_ready = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL req_before_edge: got %b expected 0", imem_req); end
    step();
    tests++; if (imem_req !== 1'b1) begin fails++; $display("[TB] FAIL first_req: got %b expected 1", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("[TB] FAIL first_addr: got %h expected 00000000", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] word;
    for (int k = 0; k < 3; k++) begin
      word = 32'h1000_0001 + 32'(k) * 32'h0101_0000;
      tests++; if (imem_req !== 1'b1) begin fails++; $display("[TB] FAIL seq_req[%0d]: got %b expected 1", k, imem_req); end
      tests++; if (imem_addr !== 32'(4 * k)) begin fails++; $display("[TB] FAIL seq_addr[%0d]: got %h expected %h", k, imem_addr, 32'(4 * k)); end
      step();
      tests++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL seq_wait_req[%0d]: got %b expected 0", k, imem_req); end
      imem_rvalid = 1'b1; imem_rdata = word;
      step();
      imem_rvalid = 1'b0; imem_rdata = 32'hBAD0_BAD0;
      tests++; if (I !== word) begin fails++; $display("[TB] FAIL seq_I[%0d]: got %h expected %h", k, I, word); end
      tests++; if (PC !== 32'(4 * k)) begin fails++; $display("[TB] FAIL seq_PC[%0d]: got %h expected %h", k, PC, 32'(4 * k)); end
      for (int c = 0; c < 3; c++) begin
        tests++; if (inst_valid !== 1'b1) begin fails++; $display("[TB] FAIL seq_valid[%0d.%0d]: got %b expected 1", k, c, inst_valid); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL seq_exec_req[%0d.%0d]: got %b expected 0", k, c, imem_req); end
        step();
      end
      tests++; if (inst_valid !== 1'b0) begin fails++; $display("[TB] FAIL seq_valid_drop[%0d]: got %b expected 0", k, inst_valid); end
    end
    tests++; if (imem_addr !== 32'h0000_000C) begin fails++; $display("[TB] FAIL seq_next_addr: got %h expected 0000000c", imem_addr); end
  endtask

  task automatic test_branch();
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0040_006F;
    step();
    imem_rvalid = 1'b0;
    tests++; if (PC !== 32'h0000_000C) begin fails++; $display("[TB] FAIL br_PC: got %h expected 0000000c", PC); end
    PCSel = 1'b1; ALUout = 32'h0000_0555;
    step();
    step();
    PCSel = 1'b1; ALUout = 32'h0000_0103;
    step();
    PCSel = 1'b0; ALUout = 32'h0;
    tests++; if (imem_addr !== 32'h0000_0100) begin fails++; $display("[TB] FAIL br_taken_addr: got %h expected 00000100", imem_addr); end
    tests++; if (imem_req !== 1'b1) begin fails++; $display("[TB] FAIL br_taken_req: got %b expected 1", imem_req); end

    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0463;
    step();
    imem_rvalid = 1'b0;
    tests++; if (PC !== 32'h0000_0100) begin fails++; $display("[TB] FAIL br_target_PC: got %h expected 00000100", PC); end
    step();
    PCSel = 1'b1; ALUout = 32'h0000_0200;
    step();
    PCSel = 1'b0; ALUout = 32'h0;
    step();
    tests++; if (imem_addr !== 32'h0000_0104) begin fails++; $display("[TB] FAIL br_mid_addr: got %h expected 00000104", imem_addr); end
  endtask

  task automatic test_backpressure();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++; if (imem_addr !== 32'h0000_0104 || imem_req !== 1'b1) begin fails++; $display("[TB] FAIL bp_hold[%0d]: got addr %h req %b expected 00000104 1", i, imem_addr, imem_req); end
      step();
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_wait[%0d]: got req %b valid %b expected 0 0", i, imem_req, inst_valid); end
      tests++; if (I !== 32'h0000_0463) begin fails++; $display("[TB] FAIL bp_I_hold[%0d]: got %h expected 00000463", i, I); end
      step();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0013;
    step();
    imem_rdata = 32'hDEAD_BEEF;
    tests++; if (I !== 32'hCAFE_0013) begin fails++; $display("[TB] FAIL bp_I: got %h expected cafe0013", I); end
    tests++; if (PC !== 32'h0000_0104) begin fails++; $display("[TB] FAIL bp_PC: got %h expected 00000104", PC); end
    step();
    step();
    tests++; if (I !== 32'hCAFE_0013) begin fails++; $display("[TB] FAIL bp_spurious: got %h expected cafe0013", I); end
    imem_rvalid = 1'b0;
    imem_ready = 1'b1;
    step();
    tests++; if (inst_valid !== 1'b0 || I !== 32'hCAFE_0013) begin fails++; $display("[TB] FAIL bp_after: got valid %b I %h expected 0 cafe0013", inst_valid, I); end
    tests++; if (imem_addr !== 32'h0000_0108) begin fails++; $display("[TB] FAIL bp_next_addr: got %h expected 00000108", imem_addr); end
  endtask

  task automatic test_stall_wrap();
    int cycles;
    rst_n = 1'b0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; stall = 1'b0;
    step();
    tests++; if (w_imem_addr !== 32'hFFFF_FFFC || w_PC !== 32'hFFFF_FFFC) begin fails++; $display("[TB] FAIL wrap_reset: got addr %h PC %h expected fffffffc fffffffc", w_imem_addr, w_PC); end
    rst_n_w = 1'b1;
    step();
    tests++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("[TB] FAIL wrap_first_req: got req %b addr %h expected 1 fffffffc", w_imem_req, w_imem_addr); end
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0011_0113;
    step();
    imem_rvalid = 1'b0;
    tests++; if (w_I !== 32'h0011_0113 || w_PC !== 32'hFFFF_FFFC) begin fails++; $display("[TB] FAIL wrap_capture: got I %h PC %h expected 00110113 fffffffc", w_I, w_PC); end
    cycles = 0;
    while (w_inst_valid === 1'b1 && cycles < 20) begin
      stall = (cycles < 2);
      step();
      cycles++;
    end
    stall = 1'b0;
    tests++; if (cycles !== 5) begin fails++; $display("[TB] FAIL stall_exec_len: got %0d expected 5", cycles); end
    tests++; if (w_imem_addr !== 32'h0 || w_imem_req !== 1'b1) begin fails++; $display("[TB] FAIL wrap_addr: got addr %h req %b expected 00000000 1", w_imem_addr, w_imem_req); end
    stall = 1'b1;
    step();
    stall = 1'b0;
    tests++; if (w_imem_req !== 1'b0) begin fails++; $display("[TB] FAIL stall_in_fetch: got req %b expected 0", w_imem_req); end
    tests++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("[TB] FAIL main_held_reset: got req %b valid %b expected 0 0", imem_req, inst_valid); end
    rst_n_w = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    imem_ready = 1'b1; imem_rvalid = 1'b0; PCSel = 1'b0; stall = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    step();
    step();
    step();
    tests++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin fails++; $display("[TB] FAIL mid_pre_addr: got addr %h req %b expected 00000004 1", imem_addr, imem_req); end
    step();
    tests++; if (imem_req !== 1'b0 || I !== 32'h0050_0093) begin fails++; $display("[TB] FAIL mid_pre_wait: got req %b I %h expected 0 00500093", imem_req, I); end
    rst_n = 1'b0;
    #1;
    tests++; if (imem_addr !== 32'h0 || PC !== 32'h0) begin fails++; $display("[TB] FAIL mid_async_addr: got addr %h PC %h expected 00000000 00000000", imem_addr, PC); end
    tests++; if (I !== 32'h0000_0013 || inst_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_async_I: got I %h valid %b expected 00000013 0", I, inst_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_DEAD;
    step();
    rst_n = 1'b1;
    step();
    imem_rvalid = 1'b0;
    tests++; if (I !== 32'h0000_0013 || inst_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_dropped: got I %h valid %b expected 00000013 0", I, inst_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("[TB] FAIL mid_restart: got req %b addr %h expected 1 00000000", imem_req, imem_addr); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_backpressure();
    test_stall_wrap();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
